// File: rtl/ysyx_22050612_mem_arbiter_pkg.sv
// Shared encodings and defaults for the IFU/LSU memory-port arbiter.
package ysyx_22050612_mem_arbiter_pkg;

    localparam int ARB_AW      = 64;
    localparam int ARB_DW      = 64;
    localparam int ARB_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_22050612_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that was not granted last. Purely combinational.
module ysyx_22050612_rr_arb2
    import ysyx_22050612_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == OWN_LS) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight.
//
// state | meaning
// IDLE  | grant offered combinationally, waiting for a handshake
// REQ   | captured request presented to memory until accepted
// WAIT  | counting cycles for the memory response or timeout
// RESP  | one-cycle response pulse to the owning requester
module ysyx_22050612_mem_arbiter
    import ysyx_22050612_mem_arbiter_pkg::*;
#(
    parameter int AW      = ARB_AW,
    parameter int DW      = ARB_DW,
    parameter int TIMEOUT = ARB_TIMEOUT,
    localparam int WMW    = DW / 8
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           if_req_valid,
    output logic           if_req_ready,
    input  logic [AW-1:0]  if_addr,
    output logic           if_resp_valid,
    output logic [DW-1:0]  if_rdata,

    input  logic           ls_req_valid,
    output logic           ls_req_ready,
    input  logic [AW-1:0]  ls_addr,
    input  logic           ls_wen,
    input  logic [DW-1:0]  ls_wdata,
    input  logic [WMW-1:0] ls_wmask,
    output logic           ls_resp_valid,
    output logic [DW-1:0]  ls_rdata,

    output logic           mem_req_valid,
    input  logic           mem_req_ready,
    output logic [AW-1:0]  mem_addr,
    output logic           mem_wen,
    output logic [DW-1:0]  mem_wdata,
    output logic [WMW-1:0] mem_wmask,
    input  logic           mem_resp_valid,
    input  logic [DW-1:0]  mem_rdata,

    output logic           timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e    state;
    arb_state_e    state_nxt;
    owner_e        owner_q;
    owner_e        last_grant;
    logic          err_q;
    logic [CW-1:0] cnt;

    logic [1:0]    req_vec;
    logic [1:0]    gnt;
    logic          hs_if;
    logic          hs_ls;
    logic          timeout_hit;
    logic          wait_done;
    logic [DW-1:0] resp_data;

    assign req_vec = {ls_req_valid, if_req_valid};

    ysyx_22050612_rr_arb2 u_rr_arb2 (
        .req  (req_vec),
        .last (last_grant),
        .gnt  (gnt)
    );

    // Ready is suppressed while reset is held so nothing is accepted in that window.
    assign if_req_ready = !rst && (state == ST_IDLE) && gnt[0];
    assign ls_req_ready = !rst && (state == ST_IDLE) && gnt[1];
    assign hs_if        = if_req_valid && if_req_ready;
    assign hs_ls        = ls_req_valid && ls_req_ready;

    assign timeout_hit  = (cnt == CW'(TIMEOUT - 1));
    assign wait_done    = mem_resp_valid || timeout_hit;
    assign resp_data    = (mem_resp_valid && !mem_wen) ? mem_rdata : '0;

    assign mem_req_valid = (state == ST_REQ);
    assign if_resp_valid = (state == ST_RESP) && (owner_q == OWN_IF);
    assign ls_resp_valid = (state == ST_RESP) && (owner_q == OWN_LS);
    assign timeout_err   = (state == ST_RESP) && err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (hs_if || hs_ls) state_nxt = ST_REQ;
            ST_REQ:  if (mem_req_ready)  state_nxt = ST_WAIT;
            ST_WAIT: if (wait_done)      state_nxt = ST_RESP;
            ST_RESP:                     state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner_q    <= OWN_IF;
            last_grant <= OWN_IF;
            err_q      <= 1'b0;
            cnt        <= '0;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (hs_ls) begin
                        owner_q    <= OWN_LS;
                        last_grant <= OWN_LS;
                        mem_addr   <= ls_addr;
                        mem_wen    <= ls_wen;
                        mem_wdata  <= ls_wdata;
                        mem_wmask  <= ls_wen ? ls_wmask : '0;
                    end else if (hs_if) begin
                        owner_q    <= OWN_IF;
                        last_grant <= OWN_IF;
                        mem_addr   <= if_addr;
                        mem_wen    <= 1'b0;
                        mem_wdata  <= '0;
                        mem_wmask  <= '0;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) cnt <= '0;
                end
                ST_WAIT: begin
                    cnt <= cnt + CW'(1);
                    // A response arriving on the timeout cycle still wins.
                    if (wait_done) begin
                        if (owner_q == OWN_IF) if_rdata <= resp_data;
                        else                   ls_rdata <= resp_data;
                        if (!mem_resp_valid) err_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: table of single
// transactions plus hand-written reset, round-robin and abort sequences.
module tb_ysyx_22050612_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        timeout_err;

    ysyx_22050612_mem_arbiter #(.AW(64), .DW(64), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        port;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          d;
        logic        mute;
        logic        exp_wen;
        logic [7:0]  exp_mask;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    exp_t q_req_if[$], q_req_ls[$], q_rsp_if[$], q_rsp_ls[$];
    logic grant_log[$];
    int   cyc = 0;
    int   acc_if, acc_ls;
    logic last_own;
    logic [63:0] model_if, model_ls;
    int   mem_delay;
    logic mem_mute;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0413_0000_0297;
        return {a[31:0], ~a[31:0]};
    endfunction

    task automatic push_exp(input logic port, input exp_t e, input logic rsp);
        if (port) begin
            q_req_ls.push_back(e);
            if (rsp) q_rsp_ls.push_back(e);
        end else begin
            q_req_if.push_back(e);
            if (rsp) q_rsp_if.push_back(e);
        end
    endtask

    // Response / handshake monitor, sampled on the falling edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (if_req_ready && ls_req_ready) fail_now("both_ready");
            if (if_req_valid && if_req_ready) begin
                acc_if = cyc; last_own = 1'b0; grant_log.push_back(1'b0);
            end
            if (ls_req_valid && ls_req_ready) begin
                acc_ls = cyc; last_own = 1'b1; grant_log.push_back(1'b1);
            end
            if (if_resp_valid) begin
                if (q_rsp_if.size() == 0) fail_now("if_resp_unexpected");
                else begin
                    e = q_rsp_if.pop_front();
                    chk("if_rdata", if_rdata, e.rdata);
                    chk("if_timeout_err", {63'b0, timeout_err}, {63'b0, e.err});
                    chk("if_latency", 64'(cyc - acc_if), 64'(e.lat));
                    chk("if_ls_resp_excl", {63'b0, ls_resp_valid}, 64'b0);
                    model_if = e.rdata;
                end
            end
            if (ls_resp_valid) begin
                if (q_rsp_ls.size() == 0) fail_now("ls_resp_unexpected");
                else begin
                    e = q_rsp_ls.pop_front();
                    chk("ls_rdata", ls_rdata, e.rdata);
                    chk("ls_timeout_err", {63'b0, timeout_err}, {63'b0, e.err});
                    chk("ls_latency", 64'(cyc - acc_ls), 64'(e.lat));
                    model_ls = e.rdata;
                end
            end
            if (timeout_err && !if_resp_valid && !ls_resp_valid) fail_now("timeout_err_alone");
        end
    end

    // Memory model: checks request fields at accept, responds mem_delay cycles later.
    initial begin
        exp_t e;
        logic        pend;
        int          left;
        logic [63:0] pdata;
        pend = 1'b0; left = 0; pdata = '0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req_valid && mem_req_ready) begin
                if ((last_own ? q_req_ls.size() : q_req_if.size()) == 0) fail_now("mem_req_unexpected");
                else begin
                    e = last_own ? q_req_ls.pop_front() : q_req_if.pop_front();
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_wen", {63'b0, mem_wen}, {63'b0, e.wen});
                    chk("mem_wmask", {56'b0, mem_wmask}, {56'b0, e.wmask});
                    if (e.wen) chk("mem_wdata", mem_wdata, e.wdata);
                end
                if (!mem_mute) begin
                    pend  = 1'b1;
                    left  = mem_delay;
                    pdata = mem_wen ? 64'hBAD0_BAD0_BAD0_BAD0 : mem_fn(mem_addr);
                end
            end
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            if (pend) begin
                left--;
                if (left == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = pdata;
                    pend           = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic port, input logic [63:0] addr, input logic wen,
                         input logic [63:0] wdata, input logic [7:0] wmask, input int d,
                         input logic mute, input exp_t e, input logic rsp);
        logic got;
        push_exp(port, e, rsp);
        mem_delay = d;
        mem_mute  = mute;
        if (port) begin
            ls_addr = addr; ls_wen = wen; ls_wdata = wdata; ls_wmask = wmask; ls_req_valid = 1'b1;
        end else begin
            if_addr = addr; if_req_valid = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = port ? ls_req_ready : if_req_ready;
            @(posedge clk); #1;
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        if (!got) fail_now("issue_no_handshake");
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((q_rsp_if.size() + q_rsp_ls.size()) != 0 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 40) begin
            fail_now("response_wait_expired");
            q_rsp_if.delete(); q_rsp_ls.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        exp_t        e;
        logic        gi, gl, saw;
        int          issued, grants, k_if, k_ls;
        logic [63:0] a;

        vecs[0] = '{1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 2, 1'b0, 1'b0, 8'h00, 64'h0000_0413_0000_0297, 1'b0, 4};
        vecs[1] = '{1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1, 1'b0, 1'b1, 8'h0F, 64'h0, 1'b0, 3};
        vecs[2] = '{1'b1, 64'h8000_2000, 1'b0, 64'h1111, 8'hFF, 3, 1'b0, 1'b0, 8'h00, 64'h8000_2000_7FFF_DFFF, 1'b0, 5};
        vecs[3] = '{1'b0, 64'h8000_0010, 1'b0, 64'h0, 8'h00, TO, 1'b0, 1'b0, 8'h00, 64'h8000_0010_7FFF_FFEF, 1'b0, TO + 2};
        vecs[4] = '{1'b1, 64'h8000_3000, 1'b0, 64'h0, 8'h3C, 1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b1, TO + 2};
        vecs[5] = '{1'b0, 64'h8000_0020, 1'b0, 64'h0, 8'h00, 1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b1, TO + 2};
        vecs[6] = '{1'b1, 64'h8000_0040, 1'b0, 64'h0, 8'h00, 1, 1'b0, 1'b0, 8'h00, 64'h8000_0040_7FFF_FFBF, 1'b0, 3};
        vecs[7] = '{1'b1, 64'h8000_0050, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hA5, 5, 1'b0, 1'b1, 8'hA5, 64'h0, 1'b0, 7};

        model_if = '0; model_ls = '0; last_own = 1'b0; acc_if = 0; acc_ls = 0;
        mem_delay = 1; mem_mute = 1'b0;

        // Reset with both requesters valid, then continuous contention.
        rst = 1'b1;
        k_if = 0; k_ls = 0;
        if_addr = 64'h8000_0400; if_req_valid = 1'b1;
        ls_addr = 64'h8000_0800; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = 8'hFF; ls_req_valid = 1'b1;
        push_exp(1'b0, '{if_addr, 1'b0, 64'h0, 8'h00, mem_fn(if_addr), 1'b0, 3}, 1'b1);
        push_exp(1'b1, '{ls_addr, 1'b0, 64'h0, 8'h00, mem_fn(ls_addr), 1'b0, 3}, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", {62'b0, if_req_ready, ls_req_ready}, 64'b0);
            chk("rst_valids", {60'b0, mem_req_valid, if_resp_valid, ls_resp_valid, timeout_err}, 64'b0);
            chk("rst_mem_fields", mem_addr | mem_wdata | {55'b0, mem_wen, mem_wmask}, 64'b0);
            chk("rst_rdata", if_rdata | ls_rdata, 64'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        issued = 2; grants = 0;
        for (int c = 0; c < 200 && grants < 8; c++) begin
            @(negedge clk);
            gi = if_req_valid && if_req_ready;
            gl = ls_req_valid && ls_req_ready;
            if (c == 0) chk("first_grant_ls", {62'b0, if_req_ready, ls_req_ready}, 64'd1);
            @(posedge clk); #1;
            if (gi) begin
                grants++;
                if (issued < 8) begin
                    k_if++; issued++;
                    if_addr = 64'h8000_0400 + 64'(k_if * 4);
                    push_exp(1'b0, '{if_addr, 1'b0, 64'h0, 8'h00, mem_fn(if_addr), 1'b0, 3}, 1'b1);
                end else if_req_valid = 1'b0;
            end
            if (gl) begin
                grants++;
                if (issued < 8) begin
                    k_ls++; issued++;
                    ls_addr = 64'h8000_0800 + 64'(k_ls * 8);
                    push_exp(1'b1, '{ls_addr, 1'b0, 64'h0, 8'h00, mem_fn(ls_addr), 1'b0, 3}, 1'b1);
                end else ls_req_valid = 1'b0;
            end
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        if (grants < 8) fail_now("rr_grant_wait_expired");
        wait_idle();
        chk("rr_grant_count", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk($sformatf("rr_grant_%0d", i), {63'b0, grant_log[i]}, {63'b0, (i % 2) == 0});

        // Single-transaction table: reads, writes, timeout and its boundary.
        for (int i = 0; i < 8; i++) begin
            e = '{vecs[i].addr, vecs[i].exp_wen, vecs[i].wdata, vecs[i].exp_mask,
                  vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat};
            issue(vecs[i].port, vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].wmask,
                  vecs[i].d, vecs[i].mute, e, 1'b1);
            wait_idle();
            chk($sformatf("hold_if_rdata_v%0d", i), if_rdata, model_if);
            chk($sformatf("hold_ls_rdata_v%0d", i), ls_rdata, model_ls);
        end

        // Reset while in WAIT; the memory's late response must be ignored.
        a = 64'h8000_0060;
        issue(1'b0, a, 1'b0, 64'h0, 8'h00, 6, 1'b0, '{a, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0, 0}, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q_rsp_if.delete(); q_rsp_ls.delete();
        model_if = '0; model_ls = '0;
        chk("post_rst_rdata", if_rdata | ls_rdata, 64'b0);
        chk("post_rst_mem_addr", mem_addr, 64'b0);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if_resp_valid || ls_resp_valid || timeout_err || mem_req_valid) saw = 1'b1;
            @(posedge clk); #1;
        end
        chk("late_resp_ignored", {63'b0, saw}, 64'b0);
        a = 64'h8000_0070;
        issue(1'b0, a, 1'b0, 64'h0, 8'h00, 2, 1'b0,
              '{a, 1'b0, 64'h0, 8'h00, 64'h8000_0070_7FFF_FF8F, 1'b0, 4}, 1'b1);
        wait_idle();
        chk("after_rst_if_rdata", if_rdata, 64'h8000_0070_7FFF_FF8F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
